// File: rtl/mult_div_unit_if.sv
// Start/operand/result bundle between the control unit and the
// multicycle multiply/divide unit.
interface mult_div_unit_if;
  logic        start_mult;
  logic        start_div;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Hi;
  logic [31:0] Lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (output start_mult, start_div, A, B,
                  input  Hi, Lo, busy, done, div_zero);
  modport slave  (input  start_mult, start_div, A, B,
                  output Hi, Lo, busy, done, div_zero);
endinterface

// File: rtl/mult_div_unit.sv
// Multicycle signed multiply (radix-2 Booth) and restoring divide with
// architectural Hi/Lo registers; 32 iterations per operation.
module mult_div_unit (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [32:0] acc;      // Booth accumulator / partial remainder
  logic [31:0] mq;       // multiplier / dividend-then-quotient
  logic [31:0] mcand;    // multiplicand / divisor magnitude
  logic        qm1, neg_q, neg_r;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero;

  assign bus.Hi       = hi;
  assign bus.Lo       = lo;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.div_zero = div_zero;

  wire [31:0] abs_a = bus.A[31] ? -bus.A : bus.A;
  wire [31:0] abs_b = bus.B[31] ? -bus.B : bus.B;

  // Accumulator carries one guard bit so that subtracting 0x80000000 does
  // not overflow before the shift.
  logic [32:0] m_ext, acc_add;
  logic [65:0] booth_sh;
  always_comb begin
    m_ext = {mcand[31], mcand};
    case ({mq[0], qm1})
      2'b01:   acc_add = acc + m_ext;
      2'b10:   acc_add = acc - m_ext;
      default: acc_add = acc;
    endcase
    booth_sh = $signed({acc_add, mq, qm1}) >>> 1;
  end

  logic [32:0] rem_sh, rem_n;
  logic [33:0] diff;
  logic [31:0] quo_n;
  always_comb begin
    rem_sh = {acc[31:0], mq[31]};
    diff   = {1'b0, rem_sh} - {2'b00, mcand};
    rem_n  = diff[33] ? rem_sh : diff[32:0];
    quo_n  = {mq[30:0], ~diff[33]};
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (bus.start_mult)     state_n = MULT;
        else if (bus.start_div) state_n = (bus.B != 32'd0) ? DIV : DONE;
      end
      MULT, DIV: if (cnt == 5'd31) state_n = DONE;
      DONE:      state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0; acc <= '0; mq <= '0; mcand <= '0;
      qm1 <= 1'b0; neg_q <= 1'b0; neg_r <= 1'b0;
      hi <= '0; lo <= '0;
      busy <= 1'b0; done <= 1'b0; div_zero <= 1'b0;
    end else begin
      busy <= (state_n != IDLE);
      done <= (state_n == DONE);
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.start_mult) begin
            acc <= '0; mq <= bus.B; qm1 <= 1'b0; mcand <= bus.A;
            div_zero <= 1'b0;
          end else if (bus.start_div) begin
            if (bus.B == 32'd0) div_zero <= 1'b1;
            else begin
              div_zero <= 1'b0;
              acc <= '0; mq <= abs_a; mcand <= abs_b;
              neg_q <= bus.A[31] ^ bus.B[31];
              neg_r <= bus.A[31];
            end
          end
        end
        MULT: begin
          acc <= booth_sh[65:33];
          mq  <= booth_sh[32:1];
          qm1 <= booth_sh[0];
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) {hi, lo} <= booth_sh[64:1];
        end
        DIV: begin
          acc <= rem_n;
          mq  <= quo_n;
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            hi <= neg_r ? -rem_n[31:0] : rem_n[31:0];
            lo <= neg_q ? -quo_n : quo_n;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: cycle-exact latency, Hi/Lo results,
// divide-by-zero, start priority/ignore and mid-operation reset.
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] exp_hi = '0, exp_lo = '0;

  mult_div_unit_if bus();
  mult_div_unit dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Drives start at a negedge; returns just after edge 0 with starts cleared.
  task automatic do_start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start_mult = m; bus.start_div = d; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start_mult = 1'b0; bus.start_div = 1'b0;
  endtask

  task automatic test_reset;
    bus.start_mult = 1'b0; bus.start_div = 1'b0; bus.A = '0; bus.B = '0;
    reset = 1'b0;
    step(3);
    checks++; if (bus.Hi !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", bus.Hi); end
    checks++; if (bus.Lo !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", bus.Lo); end
    checks++; if ({bus.busy, bus.done, bus.div_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got %b want 000", {bus.busy, bus.done, bus.div_zero}); end
    @(negedge clk); reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
  endtask

  // Shared body for both op tables: exact 32-edge latency, hidden intermediates.
  task automatic run_vectors(input bit is_div, input logic [31:0] va[], input logic [31:0] vb[],
                             input logic [31:0] vhi[], input logic [31:0] vlo[]);
    for (int i = 0; i < va.size(); i++) begin
      do_start(!is_div, is_div, va[i], vb[i]);
      checks++; if ({bus.busy, bus.done} !== 2'b10) begin
        errors++; $display("FAIL op%0d_%0d_edge0 busy/done got %b want 10", is_div, i, {bus.busy, bus.done}); end
      step(31);
      checks++; if ({bus.done, bus.Hi, bus.Lo} !== {1'b0, exp_hi, exp_lo}) begin
        errors++; $display("FAIL op%0d_%0d_edge31 done/hi/lo got %b %h %h want 0 %h %h",
                           is_div, i, bus.done, bus.Hi, bus.Lo, exp_hi, exp_lo); end
      step(1);
      exp_hi = vhi[i]; exp_lo = vlo[i];
      checks++; if ({bus.done, bus.div_zero, bus.Hi, bus.Lo} !== {2'b10, exp_hi, exp_lo}) begin
        errors++; $display("FAIL op%0d_%0d_edge32 done/dz/hi/lo got %b %b %h %h want 1 0 %h %h",
                           is_div, i, bus.done, bus.div_zero, bus.Hi, bus.Lo, exp_hi, exp_lo); end
      step(1);
      checks++; if ({bus.busy, bus.done} !== 2'b00) begin
        errors++; $display("FAIL op%0d_%0d_edge33 busy/done got %b want 00", is_div, i, {bus.busy, bus.done}); end
    end
  endtask

  task automatic test_mult;
    logic [31:0] a[]  = '{32'h7,        32'h8000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] b[]  = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h10,        32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] hi[] = '{32'hFFFF_FFFF, 32'h4000_0000, 32'h1,         32'h0,         32'hC000_0000, 32'hC000_0000};
    logic [31:0] lo[] = '{32'hFFFF_FFEB, 32'h0,         32'h2345_6780, 32'h1,         32'h8000_0000, 32'h8000_0000};
    run_vectors(1'b0, a, b, hi, lo);
  endtask

  task automatic test_div;
    logic [31:0] a[]  = '{32'hFFFF_FFF9, 32'h7,         32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 32'h8000_0000, 32'd3, 32'hFFFF_FF9C};
    logic [31:0] b[]  = '{32'd2,         32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd7,   32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFF9};
    logic [31:0] lo[] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'd14,  32'd0,         32'd1,         32'd0, 32'd14};
    logic [31:0] hi[] = '{32'hFFFF_FFFF, 32'd1,         32'd0,         32'd2,   32'hFFFF_FFFF, 32'd0,         32'd3, 32'hFFFF_FFFE};
    run_vectors(1'b1, a, b, hi, lo);
  endtask

  task automatic test_div_zero;
    do_start(1'b0, 1'b1, 32'd55, 32'd0);
    checks++; if ({bus.busy, bus.done, bus.div_zero} !== 3'b111) begin
      errors++; $display("FAIL divzero_edge0 busy/done/dz got %b want 111", {bus.busy, bus.done, bus.div_zero}); end
    checks++; if ({bus.Hi, bus.Lo} !== {exp_hi, exp_lo}) begin
      errors++; $display("FAIL divzero_hilo got %h %h want %h %h", bus.Hi, bus.Lo, exp_hi, exp_lo); end
    step(1);
    checks++; if ({bus.busy, bus.done, bus.div_zero} !== 3'b001) begin
      errors++; $display("FAIL divzero_edge1 busy/done/dz got %b want 001", {bus.busy, bus.done, bus.div_zero}); end
    step(2);
    checks++; if (bus.div_zero !== 1'b1) begin
      errors++; $display("FAIL divzero_hold got %b want 1", bus.div_zero); end
    do_start(1'b1, 1'b0, 32'd2, 32'd3);
    checks++; if (bus.div_zero !== 1'b0) begin
      errors++; $display("FAIL divzero_clear got %b want 0", bus.div_zero); end
    step(32);
    exp_hi = 32'd0; exp_lo = 32'd6;
    checks++; if ({bus.done, bus.Hi, bus.Lo} !== {1'b1, exp_hi, exp_lo}) begin
      errors++; $display("FAIL divzero_next_mult got %b %h %h want 1 %h %h", bus.done, bus.Hi, bus.Lo, exp_hi, exp_lo); end
    step(1);
  endtask

  task automatic test_priority;
    do_start(1'b1, 1'b1, 32'd5, 32'd3);
    step(32);
    exp_hi = 32'd0; exp_lo = 32'd15;
    checks++; if ({bus.done, bus.Hi, bus.Lo} !== {1'b1, exp_hi, exp_lo}) begin
      errors++; $display("FAIL prio_both got %b %h %h want 1 %h %h", bus.done, bus.Hi, bus.Lo, exp_hi, exp_lo); end
    step(1);
    // Start pulse with different operands lands on edge 10 of a multiply.
    do_start(1'b1, 1'b0, 32'h1234_5678, 32'h10);
    step(9);
    @(negedge clk);
    bus.start_div = 1'b1; bus.A = 32'd9; bus.B = 32'd1;
    step(1);
    bus.start_div = 1'b0;
    checks++; if ({bus.busy, bus.done} !== 2'b10) begin
      errors++; $display("FAIL ignore_busy busy/done got %b want 10", {bus.busy, bus.done}); end
    step(21);
    checks++; if (bus.done !== 1'b0) begin
      errors++; $display("FAIL ignore_early_done got %b want 0", bus.done); end
    step(1);
    exp_hi = 32'h1; exp_lo = 32'h2345_6780;
    checks++; if ({bus.done, bus.Hi, bus.Lo} !== {1'b1, exp_hi, exp_lo}) begin
      errors++; $display("FAIL ignore_result got %b %h %h want 1 %h %h", bus.done, bus.Hi, bus.Lo, exp_hi, exp_lo); end
    step(1);
  endtask

  task automatic test_reset_abort;
    do_start(1'b0, 1'b1, 32'd100, 32'd7);
    step(14);
    @(negedge clk); reset = 1'b0;
    step(1);
    checks++; if ({bus.Hi, bus.Lo, bus.busy, bus.done, bus.div_zero} !== {64'd0, 3'b000}) begin
      errors++; $display("FAIL abort_state got %h %h %b%b%b want 0 0 000",
                         bus.Hi, bus.Lo, bus.busy, bus.done, bus.div_zero); end
    @(negedge clk); reset = 1'b1;
    exp_hi = '0; exp_lo = '0;
    do_start(1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFB);
    step(31);
    checks++; if ({bus.done, bus.Hi, bus.Lo} !== {1'b0, 64'd0}) begin
      errors++; $display("FAIL abort_mult_e31 got %b %h %h want 0 0 0", bus.done, bus.Hi, bus.Lo); end
    step(1);
    checks++; if ({bus.done, bus.Hi, bus.Lo} !== {1'b1, 32'd0, 32'd20}) begin
      errors++; $display("FAIL abort_mult_e32 got %b %h %h want 1 0 14", bus.done, bus.Hi, bus.Lo); end
    step(1);
    checks++; if ({bus.busy, bus.done} !== 2'b00) begin
      errors++; $display("FAIL abort_mult_e33 busy/done got %b want 00", {bus.busy, bus.done}); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div_zero;
    test_priority;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
